uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader in front of the RV32I SOC core. Receives a program image over the UART `RXD` line (8N1), assembles little-endian 32-bit words, writes them sequentially into the core's instruction/data RAM through a single write port, then raises `cpu_run`. The core's state machine is held in reset until `cpu_run` is high, so the core only ever fetches a fully loaded image.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Must be at least 4.
- `ADDR_WIDTH`, default 8: RAM word-address width; depth is 2^`ADDR_WIDTH` words (256).

Ports (clock and reset first):
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `RXD` in 1: UART receive line, idle high, asynchronous to `CLK`.
- `mem_we` out 1: one-cycle RAM write strobe.
- `mem_addr` out `ADDR_WIDTH`: RAM word address. Valid when `mem_we`=1.
- `mem_wdata` out 32: RAM write data. Valid when `mem_we`=1.
- `cpu_run` out 1: load complete. Sticky high until `RESET`.
- `frame_err` out 1: sticky; a byte arrived with its stop bit low.
- `overflow` out 1: sticky; the image had more words than the RAM depth.

## Operation
- `RXD` passes through a 2-flop synchronizer. Both flops reset to 1.
- Byte receiver states:
  - RX_IDLE: wait for synchronized `RXD`=0.
  - RX_START: wait `CLKS_PER_BIT/2` cycles (integer divide), then resample. If the line is high again, treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample 8 bits, LSB first, one every `CLKS_PER_BIT` cycles.
  - RX_STOP: sample after `CLKS_PER_BIT` cycles.
    - Stop bit = 1: emit an internal `byte_valid` pulse for 1 cycle.
    - Stop bit = 0: discard the byte, set `frame_err`, and go to RX_IDLE. RX_IDLE requires the line to be high before it accepts a new start.
- Loader states:
  - LEN_LO: first byte = word count N[7:0].
  - LEN_HI: second byte = N[15:8]. If N=0, go to DONE. Otherwise go to DATA with word index 0 and byte index 0.
  - DATA: bytes shift into a 32-bit assembly register, little-endian; byte k lands in bits [8k+7:8k].
    - On the 4th byte: write the assembled word with `mem_addr` = word index[`ADDR_WIDTH`-1:0].
    - If word index ≥ 2^`ADDR_WIDTH`, still write (the address wraps modulo depth) and set `overflow`.
    - Word index is 16 bits wide. After word N-1 is written, go to DONE.
  - DONE: `cpu_run`=1. The byte receiver keeps running, but its output is ignored. `mem_we` never asserts again.
- A discarded (framing-error) byte does not advance the byte index or the word index.
- Reset mid-operation: all state aborts immediately. The counters, assembly register and sticky flags clear, and the next load starts again from LEN_LO.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `frame_err`=0, `overflow`=0.
- Sample points are measured from the first `CLK` edge where the synchronized `RXD`=0 (edge E):
  - Start-bit check at E+`CLKS_PER_BIT/2`.
  - Data bit i at E+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop bit at E+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
  - `byte_valid` asserts in the cycle after the stop sample.
- RX_IDLE is re-entered in the cycle after the stop sample. A start bit arriving half a bit period later is captured; back-to-back bytes with no idle time are supported.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. They assert exactly 1 cycle after the `byte_valid` of the 4th byte and hold for 1 cycle. Between writes, `mem_addr` and `mem_wdata` hold their last values.
- `cpu_run` rises 1 cycle after the final `mem_we` pulse. When N=0, it rises 1 cycle after the `byte_valid` of LEN_HI.
- `frame_err` sets in the cycle after the failed stop sample.
- `overflow` sets together with the offending `mem_we`.

## Test plan
- Basic load, `CLKS_PER_BIT`=8. Send 02 00, then 93 01 00 00, then 13 01 10 00. Expect:
  - `mem_we` at addr 0 with 0x00000193, then at addr 1 with 0x00100113.
  - `cpu_run`=1 one cycle after the second write; `frame_err`=0.
- Zero length. Send 00 00, then 0xAA. Expect `cpu_run`=1 one cycle after the second byte and no `mem_we` ever.
- Framing error. Send 01 00, then byte 0x11 with stop bit=0, then 11 22 33 44. Expect:
  - `frame_err`=1.
  - A single write of 0x44332211 at addr 0, then `cpu_run`=1.
- Glitch and back-to-back bytes:
  - A 2-cycle low pulse on `RXD` produces no byte.
  - Four bytes sent with zero idle time between stop and start bits are all received correctly.
- Overflow, `ADDR_WIDTH`=2. Send N=5 with words 0..4 (value = index). Expect:
  - Writes to addr 0,1,2,3,0.
  - `overflow` rising with the 5th write; `cpu_run`=1 after it.
- Reset mid-word. Assert `RESET` after 2 data bytes, release it, then send a full 1-word image. Expect:
  - All outputs 0 during reset.
  - A clean single write to addr 0, with no leftover bytes from the aborted image.

Source files
------------

// File: rtl/uart_loader.sv
// Boot loader: receives an 8N1 UART image (16-bit word count, then little-endian words),
// writes it into instruction RAM and then releases the core via cpu_run.
module uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RXD,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StRxIdle,
        StRxStart,
        StRxData,
        StRxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        StLenLo,
        StLenHi,
        StData,
        StDone
    } ld_state_e;

    // ------------------------------------------------------------------
    // RXD synchronizer
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    // Cleared after a framing error so a stuck-low line is not taken as a new start bit.
    logic            armed_q, armed_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        armed_d      = armed_q;

        unique case (rx_state_q)
            StRxIdle: begin
                cnt_d = '0;
                if (rxd_sync_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    rx_state_d = StRxStart;
                end
            end
            StRxStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    rx_state_d = rxd_sync_q ? StRxIdle : StRxData;
                end
            end
            StRxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = StRxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StRxStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d      = '0;
                    rx_state_d = StRxIdle;
                    if (rxd_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end
            end
            default: rx_state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state_q   <= StRxIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            armed_q      <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Image loader
    // ------------------------------------------------------------------
    ld_state_e             ld_state_q, ld_state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_run_q, cpu_run_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        ld_state_d  = ld_state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        overflow_d  = overflow_q;

        unique case (ld_state_q)
            StLenLo: begin
                if (byte_valid_q) begin
                    len_d[7:0] = shift_q;
                    ld_state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (byte_valid_q) begin
                    len_d[15:8] = shift_q;
                    word_idx_d  = '0;
                    byte_idx_d  = '0;
                    if ({shift_q, len_q[7:0]} == 16'd0) begin
                        ld_state_d = StDone;
                        cpu_run_d  = 1'b1;
                    end else begin
                        ld_state_d = StData;
                    end
                end
            end
            StData: begin
                if (byte_valid_q) begin
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {shift_q, asm_q[31:8]};
                        if ((word_idx_q >> ADDR_WIDTH) != 16'd0) begin
                            overflow_d = 1'b1;
                        end
                        word_idx_d = word_idx_q + 16'd1;
                        byte_idx_d = '0;
                        if (word_idx_q == len_q - 16'd1) begin
                            ld_state_d = StDone;
                        end
                    end else begin
                        asm_d      = {shift_q, asm_q[31:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                cpu_run_d = 1'b1;
            end
            default: ld_state_d = StLenLo;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ld_state_q  <= StLenLo;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: byte-stream model predicts write cycles/data and flag timing.
module tb_uart_loader;

    localparam int CPB   = 8;
    localparam int AW    = 2;
    localparam int H     = CPB / 2;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          RXD = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          frame_err;
    logic          overflow;

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RXD      (RXD),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_run  (cpu_run),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model state: expected writes and the cycles at which sticky outputs must be high.
    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  good[$];
    int          nlen;
    int          run_cyc;
    int          ferr_cyc;
    int          ovf_cyc;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    function automatic void model_clear();
        wq.delete();
        good.delete();
        obs_addr.delete();
        obs_data.delete();
        nlen     = 0;
        run_cyc  = -1;
        ferr_cyc = -1;
        ovf_cyc  = -1;
    endfunction

    // v = cycle in which the receiver's byte_valid would be high for this byte.
    function automatic void model_feed(input logic [7:0] b, input bit stop_ok, input int v);
        int n, j, w;
        if (!stop_ok) begin
            if (ferr_cyc < 0) ferr_cyc = v;
            return;
        end
        good.push_back(b);
        n = good.size();
        if (n == 2) begin
            nlen = {good[1], good[0]};
            if (nlen == 0) run_cyc = v + 1;
        end else if (n >= 3) begin
            j = n - 3;
            w = j / 4;
            if (j % 4 == 3 && w < nlen) begin
                wq.push_back('{v + 1, 32'(w % DEPTH),
                               {good[n-1], good[n-2], good[n-3], good[n-4]}});
                if (w >= DEPTH && ovf_cyc < 0) ovf_cyc = v + 1;
                if (w == nlen - 1) run_cyc = v + 2;
            end
        end
    endfunction

    always @(negedge CLK) begin
        logic exp_we;
        if (RESET) begin
            check("reset_flags", {28'd0, mem_we, cpu_run, frame_err, overflow}, 32'd0);
            check("reset_addr", 32'(mem_addr), 32'd0);
            check("reset_wdata", mem_wdata, 32'd0);
        end else begin
            exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
            check("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                check("mem_addr", 32'(mem_addr), wq[0].addr);
                check("mem_wdata", mem_wdata, wq[0].data);
                void'(wq.pop_front());
            end
            if (mem_we) begin
                obs_addr.push_back(32'(mem_addr));
                obs_data.push_back(mem_wdata);
            end
            check("cpu_run", 32'(cpu_run), 32'(run_cyc >= 0 && cyc >= run_cyc));
            check("frame_err", 32'(frame_err), 32'(ferr_cyc >= 0 && cyc >= ferr_cyc));
            check("overflow", 32'(overflow), 32'(ovf_cyc >= 0 && cyc >= ovf_cyc));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        // Start edge at cycle k: 2 synchronizer cycles, FSM sees low at k+3.
        model_feed(b, stop_ok, cyc + 3 + H + 9 * CPB);
        RXD = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            step(CPB);
        end
        RXD = stop_ok;
        step(CPB);
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        step(n);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RXD   = 1'b1;
        model_clear();
        step(3);
        RESET = 1'b0;
        step(2);
    endtask

    logic [31:0] ovf_addrs[5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    initial begin
        model_clear();
        step(1);
        do_reset();

        // Basic two-word load
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(5);
        send_byte(8'h93, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(3);
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(3 * CPB);
        check("basic_nwrites", obs_addr.size(), 32'd2);
        if (obs_addr.size() == 2) begin
            check("basic_addr0", obs_addr[0], 32'd0);
            check("basic_data0", obs_data[0], 32'h0000_0193);
            check("basic_addr1", obs_addr[1], 32'd1);
            check("basic_data1", obs_data[1], 32'h0010_0113);
        end
        check("basic_run", 32'(cpu_run), 32'd1);
        check("basic_ferr", 32'(frame_err), 32'd0);
        check("basic_pending", wq.size(), 32'd0);

        // Zero length
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle(3 * CPB);
        check("zero_nwrites", obs_addr.size(), 32'd0);
        check("zero_run", 32'(cpu_run), 32'd1);

        // Framing error
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b0);
        idle(2 * CPB);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(3 * CPB);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_nwrites", obs_addr.size(), 32'd1);
        if (obs_addr.size() == 1) check("ferr_data", obs_data[0], 32'h4433_2211);
        check("ferr_run", 32'(cpu_run), 32'd1);

        // Glitch, then back-to-back bytes
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(CPB);
        RXD = 1'b0;
        step(2);
        idle(3 * CPB);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(3 * CPB);
        check("b2b_nwrites", obs_addr.size(), 32'd1);
        if (obs_addr.size() == 1) check("b2b_data", obs_data[0], 32'hEFBE_ADDE);

        // Overflow with a 4-word RAM
        do_reset();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
        end
        idle(3 * CPB);
        check("ovf_nwrites", obs_addr.size(), 32'd5);
        if (obs_addr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("ovf_addr", obs_addr[i], ovf_addrs[i]);
                check("ovf_data", obs_data[i], 32'(i));
            end
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_run", 32'(cpu_run), 32'd1);

        // Reset mid-word
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        idle(3 * CPB);
        check("rst_nwrites", obs_addr.size(), 32'd1);
        if (obs_addr.size() == 1) begin
            check("rst_addr", obs_addr[0], 32'd0);
            check("rst_data", obs_data[0], 32'h7856_3412);
        end
        check("rst_run", 32'(cpu_run), 32'd1);
        check("final_pending", wq.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
